// File: rtl/piso_pkg.sv
// Shared types and helpers for the parametrised PISO frame shifter.
package piso_pkg;

  // Frame controller states: IDLE keeps the legacy 165 behaviour, SHIFT runs a frame.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit counter width; never narrower than one bit so tiny registers still have a counter.
  function automatic int cnt_w(input int width);
    int c;
    c = $clog2(width);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/piso_frame_ctrl.sv
// Frame controller: load handshake, bit counter, BUSY/DONE status and the
// load/shift strobes that steer the shift register datapath.
module piso_frame_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = cnt_w(WIDTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            sh_ld_n_i,
  input  logic            clk_inh_i,
  input  logic            ld_valid_i,
  output logic            ld_ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [CNTW-1:0] bit_cnt_o,
  output logic            load_en_o,
  output logic            shift_en_o
);

  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

  state_e          state_q;
  logic [CNTW-1:0] cnt_q;
  logic            done_q;

  logic last_bit;
  logic frame_load;

  // Handshake and strobes; the final frame bit opens a one-cycle window for a gapless reload.
  always_comb begin
    last_bit   = (state_q == SHIFT) && !clk_inh_i && (cnt_q == LAST_CNT);
    ld_ready_o = !rst_i && ((state_q == IDLE) || last_bit);
    frame_load = ld_valid_i && ld_ready_o;
    load_en_o  = frame_load || (!rst_i && (state_q == IDLE) && !sh_ld_n_i);
    shift_en_o = !rst_i && !frame_load && !clk_inh_i &&
                 ((state_q == SHIFT) || sh_ld_n_i);
  end

  // Frame FSM with registered counter and DONE pulse; reset aborts a frame silently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_bit;
      if (frame_load) begin
        state_q <= SHIFT;
        cnt_q   <= '0;
      end else if (last_bit) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if ((state_q == SHIFT) && !clk_inh_i) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

  assign busy_o    = (state_q == SHIFT);
  assign done_o    = done_q;
  assign bit_cnt_o = cnt_q;

endmodule

// File: rtl/piso_frame_shifter.sv
// Parametrised parallel-in/serial-out shifter with legacy 165 controls and a
// framed load interface. The top holds the shift register and output mux.
module piso_frame_shifter
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0,
  localparam int CNTW     = cnt_w(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SH_LD,
  input  logic             CLK_INH,
  input  logic             SER,
  input  logic [WIDTH-1:0] PDATA,
  input  logic             LD_VALID,
  output logic             LD_READY,
  output logic             QH,
  output logic             QHb,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNTW-1:0]  BIT_CNT
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic             load_en;
  logic             shift_en;

  piso_frame_ctrl #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_ctrl (
    .clk_i      (CLK),
    .rst_i      (RST),
    .sh_ld_n_i  (SH_LD),
    .clk_inh_i  (CLK_INH),
    .ld_valid_i (LD_VALID),
    .ld_ready_o (LD_READY),
    .busy_o     (BUSY),
    .done_o     (DONE),
    .bit_cnt_o  (BIT_CNT),
    .load_en_o  (load_en),
    .shift_en_o (shift_en)
  );

  // Next register value: parallel load wins over a shift; SER fills the vacated end.
  always_comb begin
    sr_d = sr_q;
    if (load_en) begin
      sr_d = PDATA;
    end else if (shift_en) begin
      if (LSB_FIRST != 0) sr_d = {SER, sr_q[WIDTH-1:1]};
      else                sr_d = {sr_q[WIDTH-2:0], SER};
    end
  end

  // Shift register storage, cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  // Output end depends on bit order; QH comes straight from the register.
  assign QH  = (LSB_FIRST != 0) ? sr_q[0] : sr_q[WIDTH-1];
  assign QHb = ~QH;

endmodule

// File: tb/tb_piso_frame_shifter.sv
// Directed self-checking bench: MSB-first instance for legacy, frame, inhibit
// and back-to-back cases; LSB-first instance for bit order and reset abort.
module tb_piso_frame_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       sh_ld;
  logic       clk_inh;
  logic       ser;
  logic [7:0] pdata;
  logic       ld_valid;

  logic       ld_ready0, qh0, qhb0, busy0, done0;
  logic [2:0] bit_cnt0;
  logic       ld_ready1, qh1, qhb1, busy1, done1;
  logic [2:0] bit_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_frame_shifter #(.WIDTH(8), .LSB_FIRST(0)) dut0 (
    .CLK(clk), .RST(rst), .SH_LD(sh_ld), .CLK_INH(clk_inh), .SER(ser),
    .PDATA(pdata), .LD_VALID(ld_valid), .LD_READY(ld_ready0), .QH(qh0),
    .QHb(qhb0), .BUSY(busy0), .DONE(done0), .BIT_CNT(bit_cnt0)
  );

  piso_frame_shifter #(.WIDTH(8), .LSB_FIRST(1)) dut1 (
    .CLK(clk), .RST(rst), .SH_LD(sh_ld), .CLK_INH(clk_inh), .SER(ser),
    .PDATA(pdata), .LD_VALID(ld_valid), .LD_READY(ld_ready1), .QH(qh1),
    .QHb(qhb1), .BUSY(busy1), .DONE(done1), .BIT_CNT(bit_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  pat;
  logic [15:0] b2b;

  initial begin
    // 1. reset with random inputs
    rst = 1'b1;
    sh_ld = 1'($urandom); clk_inh = 1'($urandom); ser = 1'($urandom);
    pdata = 8'($urandom); ld_valid = 1'($urandom);
    for (int i = 0; i < 2; i++) begin
      step();
      sh_ld = 1'($urandom); clk_inh = 1'($urandom); ser = 1'($urandom);
      pdata = 8'($urandom); ld_valid = 1'($urandom);
      #1;
      chk("rst_qh", 32'(qh0), 32'd0);
      chk("rst_qhb", 32'(qhb0), 32'd1);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_cnt", 32'(bit_cnt0), 32'd0);
      chk("rst_ready", 32'(ld_ready0), 32'd0);
    end
    rst = 1'b0; sh_ld = 1'b1; clk_inh = 1'b1; ser = 1'b0; ld_valid = 1'b0;
    #1;
    chk("rel_ready", 32'(ld_ready0), 32'd1);

    // 2. legacy load then free shift
    sh_ld = 1'b0; pdata = 8'hD5;
    step();
    sh_ld = 1'b1;
    $display("legacy load D5 qh=%0b", qh0);
    chk("leg_load_qh", 32'(qh0), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("leg_inh_qh", 32'(qh0), 32'd1);
    end
    clk_inh = 1'b0;
    pat = 8'hD5;
    for (int i = 1; i < 10; i++) begin
      step();
      $display("legacy shift %0d qh=%0b", i, qh0);
      chk("leg_shift_qh", 32'(qh0), (i <= 7) ? 32'(pat[7-i]) : 32'd0);
      chk("leg_busy", 32'(busy0), 32'd0);
      chk("leg_cnt", 32'(bit_cnt0), 32'd0);
    end

    // 3. frame of 96, SH_LD pulsed low mid-frame
    pat = 8'h96;
    pdata = pat; ld_valid = 1'b1;
    step();
    ld_valid = 1'b0; pdata = 8'h00;
    chk("frm_qh0", 32'(qh0), 32'd1);
    chk("frm_busy0", 32'(busy0), 32'd1);
    for (int k = 1; k < 8; k++) begin
      sh_ld = (k == 3 || k == 4) ? 1'b0 : 1'b1;
      step();
      $display("frame bit %0d qh=%0b cnt=%0d", k, qh0, bit_cnt0);
      chk("frm_qh", 32'(qh0), 32'(pat[7-k]));
      chk("frm_cnt", 32'(bit_cnt0), 32'(k));
      chk("frm_busy", 32'(busy0), 32'd1);
      chk("frm_done", 32'(done0), 32'd0);
    end
    sh_ld = 1'b1;
    step();
    chk("frm_done8", 32'(done0), 32'd1);
    chk("frm_busy8", 32'(busy0), 32'd0);
    chk("frm_cnt8", 32'(bit_cnt0), 32'd0);
    step();
    chk("frm_done9", 32'(done0), 32'd0);

    // 4. inhibit mid-frame on A5
    clk_inh = 1'b1;
    step();
    pat = 8'hA5;
    pdata = pat; ld_valid = 1'b1;
    step();
    ld_valid = 1'b0; clk_inh = 1'b0;
    chk("inh_qh0", 32'(qh0), 32'd1);
    for (int k = 1; k <= 2; k++) begin
      step();
      chk("inh_qh_pre", 32'(qh0), 32'(pat[7-k]));
    end
    clk_inh = 1'b1;
    #1;
    chk("inh_ready", 32'(ld_ready0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      $display("inhibit hold %0d qh=%0b cnt=%0d", i, qh0, bit_cnt0);
      chk("inh_hold_qh", 32'(qh0), 32'(pat[5]));
      chk("inh_hold_cnt", 32'(bit_cnt0), 32'd2);
      chk("inh_hold_busy", 32'(busy0), 32'd1);
    end
    clk_inh = 1'b0;
    for (int k = 3; k < 8; k++) begin
      step();
      chk("inh_qh_post", 32'(qh0), 32'(pat[7-k]));
      chk("inh_cnt_post", 32'(bit_cnt0), 32'(k));
      chk("inh_done_early", 32'(done0), 32'd0);
    end
    step();
    $display("inhibit frame edge 11 done=%0b", done0);
    chk("inh_done11", 32'(done0), 32'd1);

    // 5. back-to-back F0 then 0F with LD_VALID held
    b2b = 16'b1111000000001111;
    pdata = 8'hF0; ld_valid = 1'b1;
    step();
    pdata = 8'h0F;
    for (int e = 0; e < 16; e++) begin
      if (e > 0) step();
      if (e == 8) ld_valid = 1'b0;
      $display("b2b edge %0d qh=%0b busy=%0b done=%0b", e, qh0, busy0, done0);
      chk("b2b_qh", 32'(qh0), 32'(b2b[15-e]));
      chk("b2b_busy", 32'(busy0), 32'd1);
      chk("b2b_done", 32'(done0), (e == 8) ? 32'd1 : 32'd0);
      if (e == 6) begin
        #1;
        chk("b2b_ready6", 32'(ld_ready0), 32'd0);
      end
      if (e == 7) begin
        #1;
        chk("b2b_ready7", 32'(ld_ready0), 32'd1);
      end
    end
    step();
    chk("b2b_done16", 32'(done0), 32'd1);
    chk("b2b_busy16", 32'(busy0), 32'd0);

    // 6. LSB-first frame of 96 aborted by reset at BIT_CNT=4
    pat = 8'h96;
    pdata = pat; ld_valid = 1'b1;
    step();
    ld_valid = 1'b0;
    chk("lsb_qh0", 32'(qh1), 32'(pat[0]));
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) chk("lsb_qh", 32'(qh1), 32'(pat[k]));
    end
    chk("lsb_cnt4", 32'(bit_cnt1), 32'd4);
    rst = 1'b1;
    step();
    $display("lsb abort qh=%0b busy=%0b done=%0b", qh1, busy1, done1);
    chk("abort_qh", 32'(qh1), 32'd0);
    chk("abort_qhb", 32'(qhb1), 32'd1);
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_cnt", 32'(bit_cnt1), 32'd0);
    chk("abort_ready", 32'(ld_ready1), 32'd0);
    rst = 1'b0; clk_inh = 1'b1;
    #1;
    chk("abort_rel_ready", 32'(ld_ready1), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_done", 32'(done1), 32'd0);
      chk("abort_idle", 32'(busy1), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_frame_shifter.md
Name: piso_frame_shifter

Overview:
Parametrised parallel-in/serial-out shift register, successor to the fixed 8-bit 165-style part.
- Keeps the legacy controls: active-low SH_LD, CLK_INH and SER cascade input.
- Generalises word width and bit order.
- Adds a frame controller: valid/ready load handshake, bit counter, BUSY/DONE status and gapless back-to-back frames.
- Sits between a parallel word source and a serial link or a daisy-chain of shifters.

Parameters:
WIDTH, 8, shift register length in bits (>=2).
LSB_FIRST, 0, 0 = PDATA[WIDTH-1] leaves first; 1 = PDATA[0] leaves first.
CNTW, $clog2(WIDTH), BIT_CNT width (derived, not overridden).

Ports:
CLK  in  1  rising-edge clock.
RST  in  1  synchronous reset, active-high.
SH_LD  in  1  legacy parallel load, active-low; honoured only in IDLE.
CLK_INH  in  1  shift inhibit, active-high; holds register and counter.
SER  in  1  serial input, fills the vacated end on each shift.
PDATA  in  WIDTH  parallel word.
LD_VALID  in  1  frame load request.
LD_READY  out  1  controller accepts PDATA this cycle.
QH  out  1  serial output, the current output-end bit.
QHb  out  1  ~QH, combinational.
BUSY  out  1  a frame is in progress.
DONE  out  1  one-cycle pulse, last frame bit shifted out.
BIT_CNT  out  CNTW  number of shifts completed in the current frame.

Behaviour:
- Single clock CLK; RST is synchronous and active-high.
- Reset: sr=0, state=IDLE, BIT_CNT=0, BUSY=0, DONE=0. QH=0 and QHb=1. LD_READY=0 while RST is high.
- Output end: sr[WIDTH-1] when LSB_FIRST=0, sr[0] when LSB_FIRST=1. QH is driven from the register with no extra latency.
- Shift direction:
  - LSB_FIRST=0: sr <= {sr[WIDTH-2:0], SER}.
  - LSB_FIRST=1: sr <= {SER, sr[WIDTH-1:1]}.
- States: IDLE, SHIFT. BUSY = (state==SHIFT).
- IDLE priority per edge: RST > frame load > legacy load > free shift.
  - Frame load (LD_VALID & LD_READY): sr<=PDATA, BIT_CNT<=0, go to SHIFT. LD_READY=1 throughout IDLE.
  - Legacy load (SH_LD=0): sr<=PDATA. State and BIT_CNT are unchanged.
  - Free shift (SH_LD=1, CLK_INH=0): shift one bit; BIT_CNT stays 0. This is legacy 165 behaviour.
- SHIFT state:
  - CLK_INH=1: sr, BIT_CNT and state hold. LD_READY=0. SH_LD is ignored.
  - CLK_INH=0 and BIT_CNT<WIDTH-1: shift one bit, BIT_CNT++.
  - CLK_INH=0 and BIT_CNT==WIDTH-1: final shift. LD_READY=1 in this cycle only.
    - With no load: shift, BIT_CNT<=0, go to IDLE, DONE=1 on the next cycle.
    - With LD_VALID=1: the load replaces the shift. sr<=PDATA, BIT_CNT<=0, stay in SHIFT, DONE=1 on the next cycle.
- Frame timing: first bit is on QH the cycle after the load edge. The frame occupies WIDTH uninhibited cycles. DONE rises WIDTH uninhibited edges after the load edge.
- RST asserted mid-frame aborts the frame. No DONE is emitted and the register clears.
- PDATA is sampled only on a load edge; changes at other times have no effect.
- SER is sampled only on shift edges.

Decomposition:
- Package piso_pkg:
  - state enum {IDLE, SHIFT}.
  - Helper function cnt_w(WIDTH) returning max(1, clog2(WIDTH)).
- Sub-module piso_frame_ctrl:
  - Contains the FSM, BIT_CNT, LD_READY, BUSY and DONE.
  - Outputs load_en and shift_en strobes.
- The top level keeps the sr datapath and the QH/QHb mux.

Test Plan (WIDTH=8 unless stated):
1. Hold RST 2 cycles with random inputs -> QH=0, QHb=1, BUSY=0, DONE=0, BIT_CNT=0, LD_READY=0 while in reset and 1 after release.
2. Legacy path:
   - Stimulus: SH_LD=0 with PDATA=8'hD5 and CLK_INH=1. Then SH_LD=1, CLK_INH=0, SER=0.
   - Response: QH stays 1 while inhibited, then sequence 1,1,0,1,0,1,0,1 followed by 0s. BUSY stays 0 throughout.
3. Frame path:
   - Stimulus: LD_VALID pulse with PDATA=8'h96, CLK_INH=0.
   - Response: QH=1,0,0,1,0,1,1,0. BUSY high for 8 cycles. DONE single pulse 8 edges after load. SH_LD=0 mid-frame is ignored.
4. Inhibit mid-frame:
   - Stimulus: frame load of 8'hA5, then CLK_INH=1 for 3 cycles once BIT_CNT reaches 2.
   - Response: QH and BIT_CNT=2 freeze. Bit order is unchanged. DONE arrives 11 edges after load.
5. Back-to-back:
   - Stimulus: LD_VALID held with 8'hF0, then 8'h0F presented.
   - Response: 16 contiguous QH bits 1111000000001111. DONE pulses at edges 8 and 16. BUSY never drops between frames.
6. LSB_FIRST=1:
   - Stimulus: frame load of 8'h96, with RST asserted at BIT_CNT=4.
   - Response: QH=0,1,1,0 before the abort. After the RST edge: QH=0, BUSY=0, no DONE, LD_READY=1 after release.
